// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_pkg
// Description : Shared branch-predictor types and constants (PHT and GHR).
// Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

    localparam int unsigned c_BPRED_WIDTH = 9;

    typedef logic [1:0] ctr2_t;

    localparam ctr2_t c_CTR_INIT = 2'b10;
    localparam ctr2_t c_CTR_MAX  = 2'b11;
    localparam ctr2_t c_CTR_MIN  = 2'b00;

    // Shared with global_history_reg, so the names stay unprefixed.
    localparam logic TAKEN     = 1'b1;
    localparam logic NOT_TAKEN = 1'b0;

endpackage : bp_pkg
`default_nettype wire

// File: rtl/bp_sat_counter2.sv
`default_nettype none
// ============================================================================
// Module      : bp_sat_counter2
// Description : Next-state function of a 2-bit saturating branch counter.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_sat_counter2
    import bp_pkg::*;
(
    input  logic [1:0] i_ctr,
    input  logic       i_outcome,
    output logic [1:0] o_ctr_next
);

    always_comb begin
        o_ctr_next = i_ctr;
        if (i_outcome == TAKEN) begin
            if (i_ctr != c_CTR_MAX) begin
                o_ctr_next = i_ctr + 2'd1;
            end
        end else begin
            if (i_ctr != c_CTR_MIN) begin
                o_ctr_next = i_ctr - 2'd1;
            end
        end
    end

endmodule : bp_sat_counter2
`default_nettype wire

// File: rtl/bp_counter_table.sv
`default_nettype none
// ============================================================================
// Module      : bp_counter_table
// Description : Gshare pattern history table of 2-bit counters, trained from EX.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_counter_table
    import bp_pkg::*;
#(
    parameter int unsigned BPRED_WIDTH = c_BPRED_WIDTH,
    parameter logic [1:0]  CTR_INIT    = c_CTR_INIT
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset,
    input  logic                   i_DEC_Is_Branch,
    input  logic [31:0]            i_DEC_PC,
    input  logic [BPRED_WIDTH-1:0] i_Global_History,
    input  logic                   i_Stall,
    input  logic                   i_Flush,
    input  logic                   i_ALU_Branch_Valid,
    input  logic                   i_ALU_Branch_Outcome,
    output logic                   o_Prediction,
    output logic                   o_Mispredict
);

    localparam int unsigned c_DEPTH = 2 ** BPRED_WIDTH;

    // Flop array rather than RAM so every entry clears in a single reset cycle.
    logic [1:0]             r_ctr [c_DEPTH];

    logic                   r_EX_Valid;
    logic [BPRED_WIDTH-1:0] r_EX_Index;
    logic                   r_EX_Pred;

    logic [BPRED_WIDTH-1:0] w_idx;
    logic                   w_pred;
    logic                   w_upd;
    logic [1:0]             w_ctr_next;
    logic                   w_unused_pc;

    assign w_idx       = i_DEC_PC[BPRED_WIDTH+1:2] ^ i_Global_History;
    assign w_unused_pc = ^{i_DEC_PC[31:BPRED_WIDTH+2], i_DEC_PC[1:0]};

    // Lookup reads the pre-update array; a same-index write lands at the edge.
    assign w_pred       = r_ctr[w_idx][1];
    assign o_Prediction = w_pred;

    assign w_upd        = i_ALU_Branch_Valid & r_EX_Valid;
    assign o_Mispredict = w_upd & (i_ALU_Branch_Outcome != r_EX_Pred);

    bp_sat_counter2 u_sat_counter (
        .i_ctr      (r_ctr[r_EX_Index]),
        .i_outcome  (i_ALU_Branch_Outcome),
        .o_ctr_next (w_ctr_next)
    );

    always_ff @(posedge i_Clk) begin
        if (!i_Reset) begin
            for (int i = 0; i < int'(c_DEPTH); i++) begin
                r_ctr[i] <= CTR_INIT;
            end
            r_EX_Valid <= 1'b0;
            r_EX_Index <= '0;
            r_EX_Pred  <= 1'b0;
        end else begin
            // Training is independent of stall; the stall owner drops the valid.
            if (w_upd) begin
                r_ctr[r_EX_Index] <= w_ctr_next;
            end
            if (!i_Stall) begin
                if (i_Flush) begin
                    r_EX_Valid <= 1'b0;
                end else begin
                    r_EX_Valid <= i_DEC_Is_Branch;
                    r_EX_Index <= w_idx;
                    r_EX_Pred  <= w_pred;
                end
            end
        end
    end

endmodule : bp_counter_table
`default_nettype wire

// File: tb/tb_bp_counter_table.sv
`default_nettype none
// ============================================================================
// Module      : tb_bp_counter_table
// Description : Directed self-checking bench for the gshare counter table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bp_counter_table;

    logic        i_Clk;
    logic        i_Reset;
    logic        i_DEC_Is_Branch;
    logic [31:0] i_DEC_PC;
    logic [8:0]  i_Global_History;
    logic        i_Stall;
    logic        i_Flush;
    logic        i_ALU_Branch_Valid;
    logic        i_ALU_Branch_Outcome;
    logic        o_Prediction;
    logic        o_Mispredict;

    int total;
    int bad;

    typedef struct {
        logic [31:0] pc;
        logic [8:0]  ghr;
        logic        outcome;
        logic        exp_pred;
        logic        exp_mis;
        logic        exp_after;
    } vec_t;

    vec_t vecs [14];

    bp_counter_table #(
        .BPRED_WIDTH (9),
        .CTR_INIT    (2'b10)
    ) dut (
        .i_Clk                (i_Clk),
        .i_Reset              (i_Reset),
        .i_DEC_Is_Branch      (i_DEC_Is_Branch),
        .i_DEC_PC             (i_DEC_PC),
        .i_Global_History     (i_Global_History),
        .i_Stall              (i_Stall),
        .i_Flush              (i_Flush),
        .i_ALU_Branch_Valid   (i_ALU_Branch_Valid),
        .i_ALU_Branch_Outcome (i_ALU_Branch_Outcome),
        .o_Prediction         (o_Prediction),
        .o_Mispredict         (o_Mispredict)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic lookup(input logic [31:0] pc, input logic [8:0] ghr);
        i_DEC_PC         = pc;
        i_Global_History = ghr;
        #1;
    endtask

    // Branch enters DEC, moves to EX, resolves, then the same DEC lookup is re-read.
    task automatic apply_vec(input vec_t v, input string name);
        i_DEC_Is_Branch    = 1'b1;
        i_ALU_Branch_Valid = 1'b0;
        lookup(v.pc, v.ghr);
        check({name, " pred"}, o_Prediction, v.exp_pred);
        tick();
        i_DEC_Is_Branch      = 1'b0;
        i_ALU_Branch_Valid   = 1'b1;
        i_ALU_Branch_Outcome = v.outcome;
        #1;
        check({name, " mispredict"}, o_Mispredict, v.exp_mis);
        tick();
        i_ALU_Branch_Valid = 1'b0;
        #1;
        check({name, " pred after"}, o_Prediction, v.exp_after);
    endtask

    initial begin
        vec_t v;
        total = 0;
        bad   = 0;

        //        pc            ghr     out   pred  mis   after
        vecs[0]  = '{32'h40,       9'h1FF, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{32'h40,       9'h1FF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{32'h40,       9'h1FF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{32'h40,       9'h000, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{32'h40,       9'h000, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{32'h40,       9'h000, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{32'h40,       9'h000, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{32'h40,       9'h000, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[8]  = '{32'h40,       9'h000, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{32'h40,       9'h000, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{32'h7FC,      9'h1FF, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{32'hABCDE004, 9'h003, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{32'h40,       9'h1FF, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{32'h40,       9'h1FF, 1'b1, 1'b0, 1'b1, 1'b1};

        i_Reset              = 1'b0;
        i_DEC_Is_Branch      = 1'b0;
        i_DEC_PC             = 32'h0;
        i_Global_History     = 9'h0;
        i_Stall              = 1'b0;
        i_Flush              = 1'b0;
        i_ALU_Branch_Valid   = 1'b0;
        i_ALU_Branch_Outcome = 1'b0;
        tick();
        i_Reset = 1'b1;
        #1;

        // Reset sweep: PC bits xor 0x155 makes idx equal the loop index.
        for (int i = 0; i < 512; i++) begin
            logic [8:0] ix;
            ix = 9'(i);
            lookup({21'd0, ix ^ 9'h155, 2'b00}, 9'h155);
            check($sformatf("reset pred idx %0d", i), o_Prediction, 1'b1);
        end
        check("reset mispredict", o_Mispredict, 1'b0);

        for (int i = 0; i < 14; i++) begin
            apply_vec(vecs[i], $sformatf("vec%0d", i));
        end
        // Now: 1EF=10, 010=10, 000=11, 002=01.

        // Same-cycle lookup/update on idx 1EF.
        i_DEC_Is_Branch = 1'b1;
        lookup(32'h40, 9'h1FF);
        tick();
        i_DEC_Is_Branch      = 1'b0;
        i_ALU_Branch_Valid   = 1'b1;
        i_ALU_Branch_Outcome = 1'b0;
        #1;
        check("hazard old pred", o_Prediction, 1'b1);
        check("hazard mispredict", o_Mispredict, 1'b1);
        tick();
        i_ALU_Branch_Valid = 1'b0;
        #1;
        check("hazard new pred", o_Prediction, 1'b0);

        // Flushed branch at idx 010 must not train.
        i_DEC_Is_Branch = 1'b1;
        i_Flush         = 1'b1;
        lookup(32'h40, 9'h000);
        tick();
        i_Flush              = 1'b0;
        i_DEC_Is_Branch      = 1'b0;
        i_ALU_Branch_Valid   = 1'b1;
        i_ALU_Branch_Outcome = 1'b0;
        #1;
        check("flush mispredict", o_Mispredict, 1'b0);
        tick();
        i_ALU_Branch_Valid = 1'b0;
        #1;
        check("flush no train", o_Prediction, 1'b1);

        // Stall holds EX idx 002 while DEC moves to idx 000.
        i_DEC_Is_Branch = 1'b1;
        lookup(32'hABCDE004, 9'h003);
        tick();
        i_Stall = 1'b1;
        lookup(32'h7FC, 9'h1FF);
        tick();
        tick();
        i_Stall              = 1'b0;
        i_DEC_Is_Branch      = 1'b0;
        i_ALU_Branch_Valid   = 1'b1;
        i_ALU_Branch_Outcome = 1'b1;
        #1;
        check("stall held pred mispredict", o_Mispredict, 1'b1);
        tick();
        i_ALU_Branch_Valid = 1'b0;
        lookup(32'hABCDE004, 9'h003);
        check("stall trained original idx", o_Prediction, 1'b1);
        lookup(32'h7FC, 9'h1FF);
        check("stall other idx intact", o_Prediction, 1'b1);

        // Reset on the same edge as an EX resolution of idx 010.
        i_DEC_Is_Branch = 1'b1;
        lookup(32'h40, 9'h000);
        tick();
        i_DEC_Is_Branch      = 1'b0;
        i_ALU_Branch_Valid   = 1'b1;
        i_ALU_Branch_Outcome = 1'b0;
        i_Reset              = 1'b0;
        tick();
        i_Reset = 1'b1;
        #1;
        check("reset midflight EX invalid", o_Mispredict, 1'b0);
        tick();
        i_ALU_Branch_Valid = 1'b0;
        lookup(32'h40, 9'h1FF);
        check("reset midflight 1EF reinit", o_Prediction, 1'b1);
        v = '{32'h40, 9'h000, 1'b0, 1'b1, 1'b1, 1'b0};
        apply_vec(v, "post reset 010 weak");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_bp_counter_table
`default_nettype wire
